// File: rtl/game_pkg.sv
// Shared types and defaults for the Game_State / match controller pair.
package game_pkg;

  typedef enum logic [1:0] {IDLE, INIT, PLAY, OVER} match_state_t;
  typedef enum logic [1:0] {RES_NONE, RES_WIN, RES_LOSE, RES_TIE} match_result_t;

  localparam int DEFAULT_WIN_ROUNDS = 15;

  function automatic match_result_t result_of(input logic win_hit, input logic lose_hit);
    if (win_hit && lose_hit) return RES_TIE;
    if (win_hit)             return RES_WIN;
    if (lose_hit)            return RES_LOSE;
    return RES_NONE;
  endfunction

endpackage

// File: rtl/game_round_counter.sv
// Saturating round counter; reached_o flags that this cycle's update lands on WIN_ROUNDS.
// Latency: count registered, reached_o combinational from clr/inc. No backpressure.
module game_round_counter
  import game_pkg::*;
#(
  parameter int WIN_ROUNDS = DEFAULT_WIN_ROUNDS,
  parameter int CNT_W      = $clog2(WIN_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             reached_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIN_ROUNDS);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign reached_o = (cnt_d == MAX_CNT);

endmodule

// File: rtl/game_match_controller.sv
// Match scorekeeper beside Game_State: counts rounds, detects match end, issues the init/load request.
// Latency: all outputs registered, one cycle after the causing input. No backpressure; abort wins everything.
module game_match_controller
  import game_pkg::*;
#(
  parameter int  WIN_ROUNDS = DEFAULT_WIN_ROUNDS,
  parameter int  VALUE_W    = 4,
  localparam int CNT_W      = $clog2(WIN_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [VALUE_W-1:0] seed_i,
  input  logic               abort_i,
  input  logic               winner_i,
  input  logic               loser_i,
  input  logic               ack_i,
  output logic               init_o,
  output logic [VALUE_W-1:0] init_value_o,
  output logic [CNT_W-1:0]   win_cnt_o,
  output logic [CNT_W-1:0]   lose_cnt_o,
  output logic               match_over_o,
  output logic [1:0]         result_o,
  output logic               busy_o
);

  match_state_t       state_d, state_q;
  match_result_t      result_d, result_q;
  logic [VALUE_W-1:0] init_value_d, init_value_q;
  logic               init_d, init_q;
  logic               over_d, over_q;
  logic               busy_d, busy_q;

  logic cnt_clr, win_inc, lose_inc;
  logic win_hit, lose_hit;

  // Counters clear on the start edge so the INIT cycle already shows a zero score.
  assign cnt_clr  = abort_i || (state_q == INIT) || ((state_q == IDLE) && start_i);
  assign win_inc  = (state_q == PLAY) && winner_i;
  assign lose_inc = (state_q == PLAY) && loser_i;

  game_round_counter #(
    .WIN_ROUNDS (WIN_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_win_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .inc_i     (win_inc),
    .cnt_o     (win_cnt_o),
    .reached_o (win_hit)
  );

  game_round_counter #(
    .WIN_ROUNDS (WIN_ROUNDS),
    .CNT_W      (CNT_W)
  ) u_lose_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .inc_i     (lose_inc),
    .cnt_o     (lose_cnt_o),
    .reached_o (lose_hit)
  );

  always_comb begin
    state_d      = state_q;
    init_value_d = init_value_q;
    result_d     = result_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d      = INIT;
          init_value_d = seed_i;
        end
      end
      INIT: state_d = PLAY;
      PLAY: begin
        if (win_hit || lose_hit) begin
          state_d  = OVER;
          result_d = result_of(win_hit, lose_hit);
        end
      end
      OVER: begin
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort undoes a same-cycle seed capture as well as the state move.
    if (abort_i) begin
      state_d      = IDLE;
      init_value_d = init_value_q;
    end

    if (state_d != OVER) result_d = RES_NONE;

    init_d = (state_d == INIT);
    busy_d = (state_d == INIT) || (state_d == PLAY);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      result_q     <= RES_NONE;
      init_value_q <= '0;
      init_q       <= 1'b0;
      over_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      init_value_q <= init_value_d;
      init_q       <= init_d;
      over_q       <= over_d;
      busy_q       <= busy_d;
    end
  end

  assign init_o       = init_q;
  assign init_value_o = init_value_q;
  assign match_over_o = over_q;
  assign result_o     = result_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_game_match_controller.sv
// Vector table plus hand sequences; expected outputs queued at drive time and checked one cycle later.
module tb_game_match_controller;

  typedef struct packed {
    logic       init;
    logic [3:0] ival;
    logic [3:0] win;
    logic [3:0] lose;
    logic       over;
    logic [1:0] res;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       st;
    logic [3:0] sd;
    logic       ab;
    logic       w;
    logic       l;
    logic       ak;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] seed_i = '0;
  logic       abort_i = 1'b0;
  logic       winner_i = 1'b0;
  logic       loser_i = 1'b0;
  logic       ack_i = 1'b0;
  logic       init_o;
  logic [3:0] init_value_o;
  logic [3:0] win_cnt_o;
  logic [3:0] lose_cnt_o;
  logic       match_over_o;
  logic [1:0] result_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  game_match_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .seed_i       (seed_i),
    .abort_i      (abort_i),
    .winner_i     (winner_i),
    .loser_i      (loser_i),
    .ack_i        (ack_i),
    .init_o       (init_o),
    .init_value_o (init_value_o),
    .win_cnt_o    (win_cnt_o),
    .lose_cnt_o   (lose_cnt_o),
    .match_over_o (match_over_o),
    .result_o     (result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic init, input logic [3:0] ival, input logic [3:0] win,
                              input logic [3:0] lose, input logic over, input logic [1:0] res,
                              input logic busy);
    exp_t e;
    e.init = init; e.ival = ival; e.win = win; e.lose = lose;
    e.over = over; e.res = res; e.busy = busy;
    return e;
  endfunction

  function automatic vec_t mv(input logic st, input logic [3:0] sd, input logic ab, input logic w,
                              input logic l, input logic ak, input exp_t e);
    vec_t v;
    v.st = st; v.sd = sd; v.ab = ab; v.w = w; v.l = l; v.ak = ak; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".init"}, int'(init_o), 0);
    chk({tag, ".ival"}, int'(init_value_o), 0);
    chk({tag, ".win"},  int'(win_cnt_o), 0);
    chk({tag, ".lose"}, int'(lose_cnt_o), 0);
    chk({tag, ".over"}, int'(match_over_o), 0);
    chk({tag, ".res"},  int'(result_o), 0);
    chk({tag, ".busy"}, int'(busy_o), 0);
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    start_i = v.st; seed_i = v.sd; abort_i = v.ab;
    winner_i = v.w; loser_i = v.l; ack_i = v.ak;
    sb_q.push_back(v.e);
    @(posedge clk);
    #1;
    start_i = 1'b0; abort_i = 1'b0; winner_i = 1'b0; loser_i = 1'b0; ack_i = 1'b0;
    if (sb_q.size() == 0) begin
      chk({tag, ".queue"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".init"}, int'(init_o), int'(e.init));
      chk({tag, ".ival"}, int'(init_value_o), int'(e.ival));
      chk({tag, ".win"},  int'(win_cnt_o), int'(e.win));
      chk({tag, ".lose"}, int'(lose_cnt_o), int'(e.lose));
      chk({tag, ".over"}, int'(match_over_o), int'(e.over));
      chk({tag, ".res"},  int'(result_o), int'(e.res));
      chk({tag, ".busy"}, int'(busy_o), int'(e.busy));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[15];
    exp_t z;

    vt[0]  = mv(1, 4'hA, 0, 0, 0, 0, mk(1, 4'hA, 0, 0, 0, 2'b00, 1));
    vt[1]  = mv(1, 4'h5, 0, 1, 0, 0, mk(0, 4'hA, 0, 0, 0, 2'b00, 1));
    vt[2]  = mv(0, 4'h0, 0, 1, 0, 0, mk(0, 4'hA, 1, 0, 0, 2'b00, 1));
    vt[3]  = mv(0, 4'h0, 0, 0, 1, 0, mk(0, 4'hA, 1, 1, 0, 2'b00, 1));
    vt[4]  = mv(0, 4'h0, 0, 1, 1, 0, mk(0, 4'hA, 2, 2, 0, 2'b00, 1));
    vt[5]  = mv(1, 4'h3, 0, 1, 0, 0, mk(0, 4'hA, 3, 2, 0, 2'b00, 1));
    vt[6]  = mv(0, 4'h0, 0, 0, 1, 0, mk(0, 4'hA, 3, 3, 0, 2'b00, 1));
    vt[7]  = mv(0, 4'h0, 0, 1, 0, 0, mk(0, 4'hA, 4, 3, 0, 2'b00, 1));
    vt[8]  = mv(0, 4'h0, 0, 1, 0, 0, mk(0, 4'hA, 5, 3, 0, 2'b00, 1));
    vt[9]  = mv(0, 4'h0, 0, 1, 0, 0, mk(0, 4'hA, 6, 3, 0, 2'b00, 1));
    vt[10] = mv(0, 4'h0, 0, 1, 0, 0, mk(0, 4'hA, 7, 3, 0, 2'b00, 1));
    vt[11] = mv(0, 4'h0, 1, 1, 0, 0, mk(0, 4'hA, 0, 0, 0, 2'b00, 0));
    vt[12] = mv(1, 4'h7, 1, 0, 0, 0, mk(0, 4'hA, 0, 0, 0, 2'b00, 0));
    vt[13] = mv(0, 4'h0, 0, 0, 0, 0, mk(0, 4'hA, 0, 0, 0, 2'b00, 0));
    vt[14] = mv(0, 4'h0, 0, 1, 1, 0, mk(0, 4'hA, 0, 0, 0, 2'b00, 0));

    z = mk(0, 0, 0, 0, 0, 2'b00, 0);

    // Reset, then round pulses in IDLE must not count.
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step("idle_pulse", mv(0, 0, 0, 1, 0, 0, z));

    // Start, ignored start/pulses in INIT, play to 7/3, abort with a winner pulse.
    for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), vt[i]);

    // Win: W L W L ... W, final winner reaches 15.
    step("win_start", mv(1, 4'h3, 0, 0, 0, 0, mk(1, 4'h3, 0, 0, 0, 2'b00, 1)));
    step("win_init",  mv(0, 0, 0, 0, 0, 0, mk(0, 4'h3, 0, 0, 0, 2'b00, 1)));
    for (int i = 1; i <= 14; i++) begin
      step("win_w", mv(0, 0, 0, 1, 0, 0, mk(0, 4'h3, 4'(i), 4'(i - 1), 0, 2'b00, 1)));
      step("win_l", mv(0, 0, 0, 0, 1, 0, mk(0, 4'h3, 4'(i), 4'(i), 0, 2'b00, 1)));
    end
    step("win_end", mv(0, 0, 0, 1, 0, 0, mk(0, 4'h3, 15, 14, 1, 2'b01, 0)));
    step("win_hold_l", mv(0, 0, 0, 0, 1, 0, mk(0, 4'h3, 15, 14, 1, 2'b01, 0)));
    step("win_hold_st", mv(1, 4'h9, 0, 1, 0, 0, mk(0, 4'h3, 15, 14, 1, 2'b01, 0)));
    step("win_hold", mv(0, 0, 0, 0, 0, 0, mk(0, 4'h3, 15, 14, 1, 2'b01, 0)));
    step("win_ack",  mv(0, 0, 0, 0, 0, 1, mk(0, 4'h3, 15, 14, 0, 2'b00, 0)));
    step("win_idle", mv(0, 0, 0, 1, 0, 0, mk(0, 4'h3, 15, 14, 0, 2'b00, 0)));

    // Tie: 14/14 then both pulses together; saturation afterwards.
    step("tie_start", mv(1, 4'h6, 0, 0, 0, 0, mk(1, 4'h6, 0, 0, 0, 2'b00, 1)));
    step("tie_init",  mv(0, 0, 0, 0, 0, 0, mk(0, 4'h6, 0, 0, 0, 2'b00, 1)));
    for (int i = 1; i <= 14; i++) begin
      step("tie_w", mv(0, 0, 0, 1, 0, 0, mk(0, 4'h6, 4'(i), 4'(i - 1), 0, 2'b00, 1)));
      step("tie_l", mv(0, 0, 0, 0, 1, 0, mk(0, 4'h6, 4'(i), 4'(i), 0, 2'b00, 1)));
    end
    step("tie_end",  mv(0, 0, 0, 1, 1, 0, mk(0, 4'h6, 15, 15, 1, 2'b11, 0)));
    step("tie_sat",  mv(0, 0, 0, 1, 1, 0, mk(0, 4'h6, 15, 15, 1, 2'b11, 0)));
    step("tie_sat2", mv(0, 0, 0, 1, 0, 0, mk(0, 4'h6, 15, 15, 1, 2'b11, 0)));
    step("tie_ack",  mv(0, 0, 0, 1, 1, 1, mk(0, 4'h6, 15, 15, 0, 2'b00, 0)));

    // Lose: 15 straight losses, then abort out of OVER.
    step("lose_start", mv(1, 4'h2, 0, 0, 0, 0, mk(1, 4'h2, 0, 0, 0, 2'b00, 1)));
    step("lose_init",  mv(0, 0, 0, 0, 0, 0, mk(0, 4'h2, 0, 0, 0, 2'b00, 1)));
    for (int i = 1; i <= 14; i++)
      step("lose_l", mv(0, 0, 0, 0, 1, 0, mk(0, 4'h2, 0, 4'(i), 0, 2'b00, 1)));
    step("lose_end",   mv(0, 0, 0, 0, 1, 0, mk(0, 4'h2, 0, 15, 1, 2'b10, 0)));
    step("lose_abort", mv(0, 0, 1, 0, 0, 1, mk(0, 4'h2, 0, 0, 0, 2'b00, 0)));

    // Async reset in PLAY between clock edges.
    step("ar_start", mv(1, 4'h9, 0, 0, 0, 0, mk(1, 4'h9, 0, 0, 0, 2'b00, 1)));
    step("ar_init",  mv(0, 0, 0, 0, 0, 0, mk(0, 4'h9, 0, 0, 0, 2'b00, 1)));
    step("ar_w1",    mv(0, 0, 0, 1, 0, 0, mk(0, 4'h9, 1, 0, 0, 2'b00, 1)));
    step("ar_w2",    mv(0, 0, 0, 1, 0, 0, mk(0, 4'h9, 2, 0, 0, 2'b00, 1)));
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("async_hold");
    rst_n = 1'b1;
    step("ar_idle",    mv(0, 0, 0, 1, 0, 0, z));
    step("ar_restart", mv(1, 4'hC, 0, 0, 0, 0, mk(1, 4'hC, 0, 0, 0, 2'b00, 1)));
    step("ar_play",    mv(0, 0, 0, 0, 0, 0, mk(0, 4'hC, 0, 0, 0, 2'b00, 1)));

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
